// File: rtl/enc_pkg.sv
// Shared constants and state encoding for the round-sequencing controller.
package enc_pkg;

  localparam int ENC_DATA_W = 64;
  localparam int ENC_ITER_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    OUT  = 2'd3
  } round_state_t;

endpackage

// File: rtl/enc_round_ctrl.sv
// Round-sequencing FSM: accepts a block, loads and steps the external
// iteration counter, applies one round per step and cross-checks the done flag.
module enc_round_ctrl
  import enc_pkg::*;
#(
  parameter int DATA_W = ENC_DATA_W,
  parameter int ITER_W = ENC_ITER_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ITER_W-1:0] in_rounds,
  output logic              ctr_load_n,
  output logic [ITER_W-1:0] iteration_value,
  output logic              start_iteration,
  input  logic              iteration_done,
  output logic              round_en,
  output logic [ITER_W-1:0] round_idx,
  output logic [DATA_W-1:0] round_data_out,
  input  logic [DATA_W-1:0] round_data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              err
);

  round_state_t      fsm_q, fsm_d;
  logic [DATA_W-1:0] state_q, state_d;
  logic [ITER_W-1:0] rounds_q, rounds_d;
  logic [ITER_W-1:0] idx_q, idx_d;
  logic              err_q, err_d;
  logic              idle_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q    <= IDLE;
      state_q  <= '0;
      rounds_q <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      rounds_q <= rounds_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    fsm_d           = fsm_q;
    state_d         = state_q;
    rounds_d        = rounds_q;
    idx_d           = idx_q;
    err_d           = err_q;
    idle_ready      = 1'b0;
    ctr_load_n      = 1'b1;
    start_iteration = 1'b0;
    round_en        = 1'b0;
    out_valid       = 1'b0;

    case (fsm_q)
      IDLE: begin
        idle_ready = 1'b1;
        if (in_valid) begin
          state_d  = in_data;
          rounds_d = in_rounds;
          idx_d    = '0;
          fsm_d    = (in_rounds == '0) ? OUT : LOAD;
        end
      end
      LOAD: begin
        ctr_load_n = 1'b0;
        fsm_d      = RUN;
      end
      RUN: begin
        // The counter's done flag must agree with the shadow index; any
        // disagreement ends the block early and flags it.
        if (!iteration_done && (idx_q < rounds_q)) begin
          round_en        = 1'b1;
          start_iteration = 1'b1;
          state_d         = round_data_in;
          idx_d           = idx_q + 1'b1;
        end else if (iteration_done && (idx_q == rounds_q)) begin
          fsm_d = OUT;
        end else begin
          err_d = 1'b1;
          fsm_d = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign in_ready        = idle_ready && !rst;
  assign iteration_value = rounds_q;
  assign round_idx       = idx_q;
  assign round_data_out  = state_q;
  assign out_data        = state_q;
  assign err             = err_q;

endmodule

// File: tb/tb_enc_round_ctrl.sv
// Directed bench for enc_round_ctrl with a behavioural iteration counter
// (real or early-done mock) and a +1 round function.
module tb_enc_round_ctrl;

  localparam int DW = 64;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [IW-1:0] in_rounds;
  logic          ctr_load_n;
  logic [IW-1:0] iteration_value;
  logic          start_iteration;
  logic          iteration_done;
  logic          round_en;
  logic [IW-1:0] round_idx;
  logic [DW-1:0] round_data_out;
  logic [DW-1:0] round_data_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          err;

  int checks = 0;
  int fails  = 0;

  logic [IW-1:0] cnt;
  int            steps;
  bit            mock = 1'b0;

  enc_round_ctrl #(.DATA_W(DW), .ITER_W(IW)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_rounds       (in_rounds),
    .ctr_load_n      (ctr_load_n),
    .iteration_value (iteration_value),
    .start_iteration (start_iteration),
    .iteration_done  (iteration_done),
    .round_en        (round_en),
    .round_idx       (round_idx),
    .round_data_out  (round_data_out),
    .round_data_in   (round_data_in),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .err             (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      steps <= 0;
    end else if (!ctr_load_n) begin
      cnt   <= iteration_value;
      steps <= 0;
    end else if (start_iteration) begin
      cnt   <= cnt - 1'b1;
      steps <= steps + 1;
    end
  end

  assign iteration_done = mock ? (steps != 0) : (cnt == '0);
  assign round_data_in  = round_data_out + 64'd1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [DW-1:0] d, input logic [IW-1:0] r);
    in_valid  = 1'b1;
    in_data   = d;
    in_rounds = r;
    chk("accept_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_rounds = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_load_n", ctr_load_n, 1);
    chk("rst_start", start_iteration, 0);
    chk("rst_round_en", round_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_idx", round_idx, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("idle_in_ready", in_ready, 1);

    // Normal 3 rounds
    accept(64'h10, 4'd3);
    chk("n3_c1_load_n", ctr_load_n, 0);
    chk("n3_c1_itval", iteration_value, 3);
    chk("n3_c1_in_ready", in_ready, 0);
    chk("n3_c1_round_en", round_en, 0);
    step();
    chk("n3_c2_load_n", ctr_load_n, 1);
    chk("n3_c2_round_en", round_en, 1);
    chk("n3_c2_start", start_iteration, 1);
    chk("n3_c2_idx", round_idx, 0);
    step();
    chk("n3_c3_idx", round_idx, 1);
    chk("n3_c3_load_n", ctr_load_n, 1);
    step();
    chk("n3_c4_idx", round_idx, 2);
    chk("n3_c4_rdo", round_data_out, 64'h12);
    step();
    chk("n3_c5_round_en", round_en, 0);
    chk("n3_c5_start", start_iteration, 0);
    chk("n3_c5_out_valid", out_valid, 0);
    step();
    chk("n3_c6_out_valid", out_valid, 1);
    chk("n3_c6_out_data", out_data, 64'h13);
    chk("n3_c6_err", err, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("n3_idle_in_ready", in_ready, 1);
    chk("n3_idle_out_valid", out_valid, 0);

    // Zero rounds
    accept(64'hAB, 4'd0);
    chk("z_c1_out_valid", out_valid, 1);
    chk("z_c1_out_data", out_data, 64'hAB);
    chk("z_c1_load_n", ctr_load_n, 1);
    chk("z_c1_start", start_iteration, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("z_idle_in_ready", in_ready, 1);

    // Backpressure with 2 rounds
    accept(64'h10, 4'd2);
    repeat (3) step();
    chk("bp_c4_out_valid", out_valid, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 64'h12);
      chk("bp_hold_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    chk("bp_release_valid", out_valid, 1);
    step();
    out_ready = 1'b0;
    chk("bp_idle_in_ready", in_ready, 1);
    chk("bp_idle_out_valid", out_valid, 0);

    // Counter reports done too early
    mock = 1'b1;
    accept(64'h10, 4'd3);
    step();
    chk("mm_c2_round_en", round_en, 1);
    step();
    chk("mm_c3_round_en", round_en, 0);
    chk("mm_c3_start", start_iteration, 0);
    step();
    chk("mm_c4_out_valid", out_valid, 1);
    chk("mm_c4_out_data", out_data, 64'h11);
    chk("mm_c4_err", err, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    mock = 1'b0;
    accept(64'h20, 4'd1);
    repeat (3) step();
    chk("mm_good_out_valid", out_valid, 1);
    chk("mm_good_out_data", out_data, 64'h21);
    chk("mm_good_err", err, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Asynchronous reset during the second round of a 5-round block
    accept(64'h30, 4'd5);
    step();
    step();
    chk("rr_c3_idx", round_idx, 1);
    chk("rr_c3_round_en", round_en, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rr_in_ready", in_ready, 0);
    chk("rr_load_n", ctr_load_n, 1);
    chk("rr_start", start_iteration, 0);
    chk("rr_round_en", round_en, 0);
    chk("rr_out_valid", out_valid, 0);
    chk("rr_err", err, 0);
    chk("rr_idx", round_idx, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      chk("rr_no_out_valid", out_valid, 0);
      step();
    end
    chk("rr_idle_in_ready", in_ready, 1);

    accept(64'h100, 4'd15);
    repeat (16) step();
    chk("r15_c17_out_valid", out_valid, 0);
    step();
    chk("r15_c18_out_valid", out_valid, 1);
    chk("r15_c18_out_data", out_data, 64'h10F);
    chk("r15_c18_err", err, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("r15_idle_in_ready", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/enc_round_ctrl.md
Name: enc_round_ctrl

Overview:
- Round-sequencing FSM for the iterative cipher core.
- Accepts one plaintext block plus a round count over a valid/ready handshake, then loads and steps the iteration down-counter.
- Applies the external round function once per step and presents the result on a valid/ready output.
- Drives the counter's load/step inputs, consumes its done flag, and cross-checks it against an internal shadow count.

Parameters:
DATA_W, 64, block width in bits
ITER_W, 4, round-count width; max rounds = 2**ITER_W-1

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input block valid
in_ready  out  1  block accepted when in_valid&&in_ready
in_data  in  DATA_W  plaintext block
in_rounds  in  ITER_W  number of rounds to apply
ctr_load_n  out  1  active-low load strobe to iteration counter
iteration_value  out  ITER_W  value loaded into counter
start_iteration  out  1  counter decrement enable
iteration_done  in  1  counter at zero
round_en  out  1  round function applied this cycle
round_idx  out  ITER_W  current round number, 0-based, for key schedule
round_data_out  out  DATA_W  current state to round function
round_data_in  in  DATA_W  combinational round result
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  ciphertext block
err  out  1  sticky counter/shadow mismatch flag

Behaviour:
- Reset (async, any state):
  - FSM returns to IDLE; state_q, rounds_q and round_idx go to 0.
  - Outputs: ctr_load_n=1; start_iteration, round_en, out_valid and err = 0; in_ready=0 while rst is high.
  - Reset mid-operation discards the block; no output is produced for it.
- States: IDLE, LOAD, RUN, OUT.
- IDLE:
  - in_ready=1.
  - On accept: state_q<=in_data, rounds_q<=in_rounds, round_idx<=0.
  - Next state is OUT if in_rounds==0, else LOAD.
- LOAD (1 cycle):
  - ctr_load_n=0, iteration_value=rounds_q.
  - Counter holds rounds_q from the next edge. Next state RUN.
- RUN, evaluated each cycle:
  - Normal step (iteration_done=0 and round_idx<rounds_q):
    - round_en=1, start_iteration=1.
    - state_q<=round_data_in, round_idx<=round_idx+1.
  - Normal finish (iteration_done=1 and round_idx==rounds_q):
    - round_en=0, start_iteration=0. Next state OUT.
  - Mismatch (any other combination):
    - err<=1; no round applied, no step. Next state OUT with state_q as is.
- OUT:
  - out_valid=1, out_data=state_q, held stable while out_ready=0.
  - On out_ready: next state IDLE.
- in_ready=0 outside IDLE; no back-to-back overlap.
- iteration_value holds rounds_q in all states.
- round_data_out = state_q at all times.
- Latency for N>0 rounds:
  - Accept at cycle 0, LOAD at cycle 1, rounds in cycles 2..N+1, done check at N+2.
  - out_valid first high at cycle N+3.
- Latency for N=0: out_valid at cycle 1; no ctr_load_n pulse, no start_iteration.
- err is sticky until reset and does not block further blocks.
- round_idx never exceeds rounds_q, so no wrap-around. Maximum rounds = 15 with ITER_W=4.

Decomposition:
- Shared package enc_pkg holds:
  - constants ENC_DATA_W=64 and ENC_ITER_W=4;
  - typedef enum logic[1:0] {IDLE,LOAD,RUN,OUT} round_state_t.
- Single flat module; no sub-module needed. The iteration counter and round function stay external and are instantiated by the enclosing core.

Test Plan:
- Normal 3 rounds. Setup: real iteration counter, mock round = +1. Stimulus: in_rounds=3, in_data=0x10. Response: one ctr_load_n low pulse, round_idx sequence 0,1,2, out_data=0x13, out_valid at cycle 6 after accept, err=0.
- Zero rounds. Stimulus: in_rounds=0, in_data=0xAB. Response: out_data=0xAB at cycle 1, ctr_load_n stays 1, start_iteration stays 0.
- Backpressure. Stimulus: rounds=2, out_ready low for 5 cycles. Response: out_valid and out_data=0x12 stable throughout, in_ready=0; IDLE one cycle after out_ready rises.
- Mismatch. Setup: mock counter asserts iteration_done after 1 step, in_rounds=3, in_data=0x10. Response: err=1, out_data=0x11, FSM reaches OUT. A following good block still completes with err held at 1.
- Reset mid-RUN. Stimulus: assert rst asynchronously during the second round of a 5-round block. Response: all outputs return to reset values immediately, no out_valid. A following block with rounds=15 yields in_data+15 at cycle 18.
